// File: rtl/serial_pkg.sv
// Frame-level definitions shared by the serial receiver and the future transmitter.
// Line format: idle high, one start bit, DATA_W data bits, one stop bit.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_rx_sync2.sv
// Two-flop synchroniser for a single asynchronous input; the reset value
// matches the line's idle level so reset never looks like an edge.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/serial_rx.sv
// Serial-to-parallel receiver: samples each bit at its centre, assembles words
// and hands them out over a valid/ready handshake that never stalls reception.
module serial_rx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              serIn,
  output logic [DATA_W-1:0] q,
  output logic              valid,
  input  logic              ready,
  output logic              frameErr,
  output logic              overrun,
  output logic              busy
);

  localparam int H     = CLKS_PER_BIT / 2;
  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(H - 1);
  localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
    $error("serial_rx: CLKS_PER_BIT must be even and >= 4");
  end
  if (DATA_W < 2) begin : g_bad_dw
    $error("serial_rx: DATA_W must be >= 2");
  end

  logic rx;

  sync2 #(
    .RST_VAL(IDLE_LEVEL)
  ) u_sync (
    .clk  (clk),
    .rst_n(reset_n),
    .d    (serIn),
    .q    (rx)
  );

  rx_state_t         state_q,    state_d;
  logic [TMR_W-1:0]  timer_q,    timer_d;
  logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [DATA_W-1:0] shreg_q,    shreg_d;
  logic [DATA_W-1:0] q_q,        q_d;
  logic              valid_q,    valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q,  overrun_d;

  logic              tick;
  logic [DATA_W-1:0] shift_in;

  // Bit order only changes which end the new sample enters.
  if (MSB_FIRST) begin : g_msb_first
    assign shift_in = {shreg_q[DATA_W-2:0], rx};
  end else begin : g_lsb_first
    assign shift_in = {rx, shreg_q[DATA_W-1:1]};
  end

  assign tick = (timer_q == '0);

  always_comb begin
    state_d     = state_q;
    timer_d     = tick ? timer_q : timer_q - 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    q_d         = q_q;
    valid_d     = valid_q && !ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = timer_q;
        if (rx == START_BIT) begin
          state_d = START;
          timer_d = TMR_HALF;
        end
      end

      START: begin
        if (tick) begin
          if (rx == START_BIT) begin
            state_d   = DATA;
            timer_d   = TMR_FULL;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (tick) begin
          shreg_d = shift_in;
          timer_d = TMR_FULL;
          if (bit_cnt_q == CNT_LAST) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (rx == STOP_BIT) begin
            state_d = IDLE;
            // A pending word consumed this very cycle frees the slot.
            if (!valid_q || ready) begin
              q_d     = shreg_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            state_d     = BREAK;
            frame_err_d = 1'b1;
          end
        end
      end

      BREAK: begin
        timer_d = timer_q;
        if (rx == IDLE_LEVEL) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      q_q         <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      q_q         <= q_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign q        = q_q;
  assign valid    = valid_q;
  assign frameErr = frame_err_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: framed words, glitch, framing error, overrun,
// simultaneous accept and mid-frame reset, with hand-computed expectations.
module tb_serial_rx;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          serIn = 1'b1;
  logic          ready = 1'b1;
  logic [DW-1:0] q;
  logic          valid;
  logic          frameErr;
  logic          overrun;
  logic          busy;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  serial_rx #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB),
    .MSB_FIRST   (1'b0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .serIn   (serIn),
    .q       (q),
    .valid   (valid),
    .ready   (ready),
    .frameErr(frameErr),
    .overrun (overrun),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (frameErr) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a falling edge; drives nb frame bits (start, data LSB first, stop),
  // returning at the falling edge after the last bit period.
  task automatic send(input logic [7:0] d, input logic stop_b, input int nb);
    logic [9:0] fr;
    fr = {stop_b, d, 1'b0};
    for (int i = 0; i < nb; i++) begin
      serIn = fr[i];
      repeat (CPB) @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    step();
    step();
    chk("rst_q", {24'd0, q}, 32'h00);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fe", {31'd0, frameErr}, 32'd0);
    chk("rst_ov", {31'd0, overrun}, 32'd0);
    reset_n = 1'b1;
    repeat (50) step();
    chk("idle_valid", {31'd0, valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_q", {24'd0, q}, 32'h00);
    chk("idle_pulses", fe_cnt + ov_cnt, 32'd0);
    $display("idle: q=0x%0h valid=%0b busy=%0b", q, valid, busy);

    // Frame 0xA5: valid rises after edge 40, lasts one cycle with ready=1.
    send(8'hA5, 1'b1, 10);
    serIn = 1'b1;
    chk("a5_valid_c40", {31'd0, valid}, 32'd0);
    chk("a5_busy_stop", {31'd0, busy}, 32'd1);
    step();
    chk("a5_valid_c41", {31'd0, valid}, 32'd1);
    chk("a5_q", {24'd0, q}, 32'hA5);
    chk("a5_busy_done", {31'd0, busy}, 32'd0);
    step();
    chk("a5_valid_drop", {31'd0, valid}, 32'd0);
    $display("frame a5: q=0x%0h", q);

    // One-cycle glitch: START entered, rejected at the half-bit check.
    repeat (5) step();
    serIn = 1'b0;
    step();
    serIn = 1'b1;
    step();
    step();
    chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
    step();
    step();
    chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
    repeat (5) step();
    chk("glitch_valid", {31'd0, valid}, 32'd0);
    chk("glitch_fe", fe_cnt, 32'd0);
    $display("glitch: busy=%0b valid=%0b", busy, valid);

    // Framing error on 0x3C, line held low for 10 more bit times.
    send(8'h3C, 1'b0, 10);
    step();
    chk("fe_pulse", {31'd0, frameErr}, 32'd1);
    chk("fe_valid", {31'd0, valid}, 32'd0);
    chk("fe_busy", {31'd0, busy}, 32'd1);
    repeat (40) step();
    chk("fe_break_busy", {31'd0, busy}, 32'd1);
    chk("fe_count", fe_cnt, 32'd1);
    chk("fe_break_valid", {31'd0, valid}, 32'd0);
    serIn = 1'b1;
    repeat (4) step();
    chk("fe_idle", {31'd0, busy}, 32'd0);
    send(8'h5A, 1'b1, 10);
    serIn = 1'b1;
    step();
    chk("5a_valid", {31'd0, valid}, 32'd1);
    chk("5a_q", {24'd0, q}, 32'h5A);
    step();
    $display("frame error then 5a: fe_cnt=%0d q=0x%0h", fe_cnt, q);

    // Overrun: 0x22 completes while 0x11 is still pending.
    ready = 1'b0;
    send(8'h11, 1'b1, 10);
    send(8'h22, 1'b1, 10);
    serIn = 1'b1;
    chk("ov_q_first", {24'd0, q}, 32'h11);
    chk("ov_valid_first", {31'd0, valid}, 32'd1);
    step();
    chk("ov_pulse", {31'd0, overrun}, 32'd1);
    chk("ov_q_kept", {24'd0, q}, 32'h11);
    chk("ov_valid_kept", {31'd0, valid}, 32'd1);
    step();
    chk("ov_one_cycle", {31'd0, overrun}, 32'd0);
    chk("ov_count", ov_cnt, 32'd1);
    ready = 1'b1;
    step();
    chk("ov_cleared", {31'd0, valid}, 32'd0);
    chk("ov_q_retain", {24'd0, q}, 32'h11);
    $display("overrun: q=0x%0h ov_cnt=%0d", q, ov_cnt);

    // Simultaneous accept: ready only in the cycle 0x22 completes.
    ready = 1'b0;
    send(8'h11, 1'b1, 10);
    send(8'h22, 1'b1, 10);
    serIn = 1'b1;
    chk("sim_q_first", {24'd0, q}, 32'h11);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("sim_q_new", {24'd0, q}, 32'h22);
    chk("sim_valid", {31'd0, valid}, 32'd1);
    chk("sim_no_ov", {31'd0, overrun}, 32'd0);
    step();
    chk("sim_valid_hold", {31'd0, valid}, 32'd1);
    chk("sim_ov_count", ov_cnt, 32'd1);
    ready = 1'b1;
    step();
    chk("sim_cleared", {31'd0, valid}, 32'd0);
    $display("simultaneous accept: q=0x%0h", q);

    // Reset while sampling data bit 4, then a clean frame.
    send(8'h00, 1'b1, 5);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_q", {24'd0, q}, 32'h00);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_pulses", {30'd0, frameErr, overrun}, 32'd0);
    @(negedge clk);
    serIn = 1'b1;
    step();
    reset_n = 1'b1;
    repeat (5) step();
    chk("mid_idle", {31'd0, busy}, 32'd0);
    send(8'hC3, 1'b1, 10);
    serIn = 1'b1;
    step();
    chk("c3_valid", {31'd0, valid}, 32'd1);
    chk("c3_q", {24'd0, q}, 32'hC3);
    step();
    chk("c3_valid_drop", {31'd0, valid}, 32'd0);
    chk("end_fe_count", fe_cnt, 32'd1);
    chk("end_ov_count", ov_cnt, 32'd1);
    $display("reset mid-frame then c3: q=0x%0h", q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
